// File: rtl/led_fade_pwm.sv
// Per-channel PWM brightness with instant attack and a timed linear decay, polarity applied at the pins.
// Latency: led_i to first lit led_o is 3 clocks; free-running stage with no backpressure.
module led_fade_pwm #(
    parameter int   CLK_IN_MHZ   = 12,
    parameter int   NUM_LEDS     = 8,
    parameter int   PWM_BITS     = 4,
    parameter int   PWM_KHZ      = 1,
    parameter int   DECAY_FRAMES = 8,
    parameter logic LED_POLARITY = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [NUM_LEDS-1:0] led_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                frame_o
);

    localparam int DIV_RAW = (CLK_IN_MHZ * 1000) / (PWM_KHZ * (1 << PWM_BITS));
    localparam int PWM_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int DEC_W   = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    localparam logic [PWM_BITS-1:0] LMAX     = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [DEC_W-1:0]    DEC_LAST = DEC_W'(DECAY_FRAMES - 1);

    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DEC_W-1:0]    decay_cnt;
    logic [NUM_LEDS-1:0] led_q;
    logic [PWM_BITS-1:0] level [NUM_LEDS];
    logic [NUM_LEDS-1:0] on;
    logic                pwm_tick;
    logic                frame_end;
    logic                decay_tick;

    assign pwm_tick   = (prescaler == PRE_LAST);
    assign frame_end  = pwm_tick && (pwm_cnt == LMAX);
    assign decay_tick = frame_end && (decay_cnt == DEC_LAST);

    always_comb begin
        on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            on[i] = enable_i && (pwm_cnt < level[i]);
        end
    end

    // Timebase keeps running while disabled so frame cadence never shifts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            decay_cnt <= '0;
            frame_o   <= 1'b0;
            led_q     <= '0;
            led_o     <= {NUM_LEDS{~LED_POLARITY}};
        end else begin
            prescaler <= pwm_tick ? '0 : prescaler + 1'b1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (frame_end) begin
                decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
            end
            frame_o <= frame_end;
            led_q   <= led_i;
            led_o   <= on ^ {NUM_LEDS{~LED_POLARITY}};
        end
    end

    // Attack outranks decay; the nonzero guard makes level saturate at 0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (rst_i || !enable_i) begin
                level[i] <= '0;
            end else if (led_q[i]) begin
                level[i] <= LMAX;
            end else if (decay_tick && (level[i] != '0)) begin
                level[i] <= level[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: 1 MHz clock, 16 kHz PWM, 4-bit levels, 2 frames per decay step (48-clock frame).
// Two instances share stimulus: active-high and active-low pin polarity.
module tb_led_fade_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] led;
    logic [7:0] led_o;
    logic [7:0] led_n;
    logic       frame_o;
    logic       frame_n;

    int n_chk  = 0;
    int n_fail = 0;
    int hi;
    int lo;
    int fr;
    int n;

    typedef struct {
        logic [7:0] led;
        logic       en;
        int         ch;
        int         exp;
    } vec_t;

    vec_t vecs[7];

    led_fade_pwm #(
        .CLK_IN_MHZ(1), .NUM_LEDS(8), .PWM_BITS(4), .PWM_KHZ(16),
        .DECAY_FRAMES(2), .LED_POLARITY(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .led_i(led),
        .led_o(led_o), .frame_o(frame_o)
    );

    led_fade_pwm #(
        .CLK_IN_MHZ(1), .NUM_LEDS(8), .PWM_BITS(4), .PWM_KHZ(16),
        .DECAY_FRAMES(2), .LED_POLARITY(1'b0)
    ) dut_n (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .led_i(led),
        .led_o(led_n), .frame_o(frame_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Step n negedges; hi = lit cycles of dut, lo = lit (low) cycles of dut_n, fr = frame pulses.
    task automatic run(input int cycles, input int ch);
        hi = 0;
        lo = 0;
        fr = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            hi += int'(led_o[ch]);
            lo += int'(!led_n[ch]);
            fr += int'(frame_o);
        end
    endtask

    task automatic wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 200);
        if (!frame_o) chk("wait_frame_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{led: 8'h01, en: 1'b1, ch: 0, exp: 45};
        vecs[1] = '{led: 8'h01, en: 1'b1, ch: 1, exp: 0};
        vecs[2] = '{led: 8'hA5, en: 1'b1, ch: 5, exp: 45};
        vecs[3] = '{led: 8'hA5, en: 1'b1, ch: 0, exp: 45};
        vecs[4] = '{led: 8'hFF, en: 1'b0, ch: 2, exp: 0};
        vecs[5] = '{led: 8'hFF, en: 1'b1, ch: 2, exp: 45};
        vecs[6] = '{led: 8'hFF, en: 1'b1, ch: 7, exp: 45};

        rst = 1'b1;
        en  = 1'b1;
        led = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_led", int'(led_o), 0);
            chk("rst_led_n", int'(led_n), 255);
            chk("rst_frame", int'(frame_o), 0);
            chk("rst_frame_n", int'(frame_n), 0);
        end
        rst = 1'b0;
        led = 8'h00;
        wait_frame();
        chk("first_frame", n, 48);
        chk("idle_led", int'(led_o), 0);
        wait_frame();
        chk("frame_period", n, 48);

        // Steady-state duty per vector: one settling frame, then a frame-aligned window.
        for (int v = 0; v < 7; v++) begin
            led = vecs[v].led;
            en  = vecs[v].en;
            wait_frame();
            chk($sformatf("vec%0d_frame", v), n, 48);
            run(48, vecs[v].ch);
            chk($sformatf("vec%0d_duty", v), hi, vecs[v].exp);
            chk($sformatf("vec%0d_duty_n", v), lo, vecs[v].exp);
        end

        // Disable for 10 clocks from frame start; re-enable with no fade-in.
        en = 1'b0;
        @(negedge clk);
        chk("dis_led", int'(led_o), 0);
        chk("dis_led_n", int'(led_n), 255);
        run(9, 0);
        chk("dis_dark", hi, 0);
        chk("dis_frames", fr, 0);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("en_led", int'(led_o), 255);
        chk("en_led_n", int'(led_n), 0);
        wait_frame();
        chk("en_cadence", n + 12, 48);

        // Fade on channel 3: first step at the next even frame end after the drop.
        led = 8'h08;
        run(100, 3);
        led = 8'h00;
        wait_frame();
        chk("fade_align", n, 44);
        for (int k = 0; k < 16; k++) begin
            run(48, 3);
            chk($sformatf("fade%0d", k), hi, 3 * (14 - k / 2));
            chk($sformatf("fade%0d_n", k), lo, 3 * (14 - k / 2));
        end
        run(48, 3);
        chk("fade_l6", hi, 18);

        // One-cycle retrigger whose led_q lands on the decay_tick cycle.
        run(46, 3);
        led = 8'h08;
        run(1, 3);
        led = 8'h00;
        run(1, 3);
        chk("retrig_frame", int'(frame_o), 1);
        run(48, 3);
        chk("retrig_duty", hi, 45);
        chk("retrig_duty_n", lo, 45);

        // Fade back down to 9, then reset mid-fade.
        run(48 * 11, 3);
        run(48, 3);
        chk("fade_l9", hi, 27);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_led", int'(led_o), 0);
        chk("midrst_led_n", int'(led_n), 255);
        chk("midrst_frame", int'(frame_o), 0);
        rst = 1'b0;
        wait_frame();
        chk("midrst_first_frame", n, 48);
        run(48, 3);
        chk("midrst_no_glow", hi, 0);
        chk("midrst_no_glow_n", lo, 0);
        run(48 * 4, 3);
        chk("midrst_stays_dark", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the LED pattern generators (KITT scanner, discrete LED drivers). Sits between their logical LED vector and the board pins.
- Converts each on/off LED bit into a PWM-driven brightness level.
- Attack is instant; decay is a timed linear fade, which gives the scanner a glowing trail.
- Board polarity is applied here, so upstream drivers feeding this block are configured with LED_POLARITY = 1'b1 (logical 1 = on).

Parameters:
- CLK_IN_MHZ, 12, input clock frequency in MHz.
- NUM_LEDS, 8, number of LED channels.
- PWM_BITS, 4, width of the PWM counter and of each brightness level.
- PWM_KHZ, 1, target PWM frame rate in kHz.
- DECAY_FRAMES, 8, PWM frames per one-step brightness decrement (>=1).
- LED_POLARITY, 1'b1, pin level that lights an LED.
- Derived: PWM_DIV = max(1, CLK_IN_MHZ*1000 / (PWM_KHZ * 2^PWM_BITS)), integer division. LMAX = 2^PWM_BITS - 1.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset: synchronous, active-high.
- enable_i  input  1  1 = normal operation; 0 = all LEDs dark.
- led_i  input  NUM_LEDS  logical LED request (1 = on) from the upstream pattern driver.
- led_o  output  NUM_LEDS  PWM pin drive, polarity applied.
- frame_o  output  1  one-cycle pulse on the last clock of each PWM frame.

Behaviour:
- Reset (rst_i high at a clk_i edge, synchronous, active-high). All of the following are forced together:
  - prescaler = 0, pwm_cnt = 0, decay counter = 0
  - all levels = 0, led_q = 0
  - led_o = {NUM_LEDS{~LED_POLARITY}}, frame_o = 0
  - Reset mid-fade discards all levels immediately.
- Prescaler: counts 0..PWM_DIV-1 and wraps. pwm_tick = 1 when prescaler == PWM_DIV-1.
- PWM counter: pwm_cnt (PWM_BITS wide) increments on pwm_tick and wraps LMAX -> 0.
- Frame end: frame_end = pwm_tick and pwm_cnt == LMAX.
  - frame_o is registered: high for exactly one cycle, the cycle after frame_end.
  - Frame length = PWM_DIV * 2^PWM_BITS clocks.
- Decay counter: counts frame_end events 0..DECAY_FRAMES-1. decay_tick = frame_end and counter == DECAY_FRAMES-1, then the counter wraps to 0.
- Input register: led_q <= led_i every cycle. This is the only sampling point; led_i is assumed synchronous to clk_i.
- Level update per channel i, evaluated every cycle in priority order:
  1. enable_i == 0: level = 0.
  2. led_q[i] == 1: level = LMAX (attack; wins over a simultaneous decay_tick).
  3. decay_tick and level > 0: level = level - 1.
  4. Otherwise: hold.
  - Level never underflows; it saturates at 0.
- Output:
  - on[i] = enable_i and (pwm_cnt < level[i]).
  - led_o[i] <= on[i] ? LED_POLARITY : ~LED_POLARITY (registered).
  - Duty = level / 2^PWM_BITS. Level LMAX gives LMAX/2^PWM_BITS duty (never 100%). Level 0 gives 0%.
- Latency:
  - led_i rising to first lit led_o edge = 3 clocks, provided pwm_cnt != LMAX at that point.
  - led_i falling does not darken the LED immediately. Full fade LMAX -> 0 takes LMAX * DECAY_FRAMES frames, the first step landing at the next decay_tick.
- enable_i low: led_o goes dark within 1 clock (registered). Counters keep running so frame timing is undisturbed.
- Channels are fully independent. No cross-channel arithmetic.

Test Plan:
Use CLK_IN_MHZ=1, PWM_KHZ=16, PWM_BITS=4, DECAY_FRAMES=2, LED_POLARITY=1 unless noted. This gives PWM_DIV=3 and a frame of 48 clocks.
- Reset/idle: hold rst_i 5 cycles with led_i=8'hFF -> led_o=8'h00 and frame_o=0 throughout; after release, frame_o pulses every 48 clocks, first pulse 48 clocks after release.
- Full on: led_i=8'h01 held -> led_o[0] high 45 of every 48 clocks (low only while pwm_cnt=15); led_o[7:1]=0.
- Fade: assert led_i[3] for 100 clocks, then drop -> duty steps 15/16, 14/16 ... 0, one step per 2 frames (96 clocks); led_o[3] stays low after 15 steps and level never wraps to 15.
- Retrigger: during the fade at level 6, reassert led_i[3] in a cycle coinciding with decay_tick -> level = 15 (attack wins); duty returns to 15/16 in the next frame.
- Enable/polarity: LED_POLARITY=0, led_i=8'hFF, drop enable_i for 10 clocks -> led_o=8'hFF (dark) one clock later, frame_o cadence unchanged; raise enable_i -> full brightness resumes with no fade-in.
- Reset mid-fade: rst_i for 1 cycle at level 9 -> next cycle led_o inactive, level=0; no residual glow once led_i=0.
